// File: rtl/crossbar_pkg.sv
// Shared constants for the SRAM bank crossbar family (request side,
// response side and the SRAM wrapper).
package crossbar_pkg;

    localparam int MUX_IN_DEF  = 4;   // default number of PEs
    localparam int MUX_OUT_DEF = 4;   // default number of SRAM banks
    localparam int DATA_W      = 32;  // SRAM word width
    localparam int BIT_CONF    = 2;   // lowest address bit of the bank select (word interleave)
    localparam int N_BANK      = MUX_OUT_DEF;
    localparam int BANK_SEL_W  = $clog2(N_BANK);

    typedef logic [DATA_W-1:0] word_t;

    // Bank index addressed by a byte address.
    function automatic logic [BANK_SEL_W-1:0] bank_of(input logic [31:0] addr);
        return addr[BIT_CONF +: BANK_SEL_W];
    endfunction

endpackage

// File: rtl/crossbar_resp_pipe.sv
// {sel, rd} delay line for one bank. Depth matches the SRAM read latency so
// the owner selection lines up with the bank's read data. No enable: every
// stage advances every cycle.
module crossbar_resp_pipe
    import crossbar_pkg::*;
#(
    parameter int N     = MUX_IN_DEF,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sel_i,
    input  logic         rd_i,
    output logic [N-1:0] sel_o,
    output logic         rd_o
);

    logic [DEPTH-1:0][N-1:0] sel_q, sel_d;
    logic [DEPTH-1:0]        rd_q, rd_d;

    // Shift: stage 0 takes the new capture, each later stage takes its predecessor.
    always_comb begin
        sel_d    = '0;
        rd_d     = '0;
        sel_d[0] = sel_i;
        rd_d[0]  = rd_i;
        for (int i = 1; i < DEPTH; i++) begin
            sel_d[i] = sel_q[i-1];
            rd_d[i]  = rd_q[i-1];
        end
    end

    // Stage registers; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            rd_q  <= '0;
        end else begin
            sel_q <= sel_d;
            rd_q  <= rd_d;
        end
    end

    assign sel_o = sel_q[DEPTH-1];
    assign rd_o  = rd_q[DEPTH-1];

endmodule

// File: rtl/crossbar_out_resp.sv
// Response-side crossbar: grants, delayed owner tracking per bank, response
// steering back to the PEs and saturating per-PE conflict counters.
// RD_LATENCY must be 1 or 2 to match the SRAM macro.
module crossbar_out_resp
    import crossbar_pkg::*;
#(
    parameter int MUX_IN     = MUX_IN_DEF,
    parameter int MUX_OUT    = MUX_OUT_DEF,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [MUX_IN-1:0]         rden_i,
    input  logic [MUX_IN-1:0]         wren_i,
    input  logic [MUX_OUT*MUX_IN-1:0] peID_i,
    input  logic [MUX_OUT*DATA_W-1:0] rdata_i,
    input  logic                      clr_cnt_i,
    output logic [MUX_IN-1:0]         gnt_o,
    output logic [MUX_IN-1:0]         resp_valid_o,
    output logic [MUX_IN-1:0]         resp_rd_o,
    output logic [MUX_IN*DATA_W-1:0]  rdata_o,
    output logic [MUX_IN*CNT_W-1:0]   conflict_cnt_o
);

    logic [MUX_IN-1:0]                req;
    logic [MUX_IN-1:0]                stall;
    logic [MUX_OUT-1:0][MUX_IN-1:0]   sel0;
    logic [MUX_OUT-1:0]               rd0;
    logic [MUX_OUT-1:0][MUX_IN-1:0]   sel_q;
    logic [MUX_OUT-1:0]               rd_q;
    logic [MUX_IN-1:0][CNT_W-1:0]     cnt_q, cnt_d;

    // Grant is the OR of every bank's owner vector; purely combinational, not reset-gated.
    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < MUX_OUT; b++) begin
            gnt_o = gnt_o | peID_i[b*MUX_IN +: MUX_IN];
        end
    end

    assign req   = rden_i | wren_i;
    assign stall = req & ~gnt_o;

    // Per-bank capture; a PE raising both rden and wren is treated as a write.
    always_comb begin
        sel0 = '0;
        rd0  = '0;
        for (int b = 0; b < MUX_OUT; b++) begin
            sel0[b] = peID_i[b*MUX_IN +: MUX_IN];
            rd0[b]  = |(peID_i[b*MUX_IN +: MUX_IN] & rden_i & ~wren_i);
        end
    end

    for (genvar b = 0; b < MUX_OUT; b++) begin : g_bank
        crossbar_resp_pipe #(
            .N     (MUX_IN),
            .DEPTH (RD_LATENCY)
        ) u_pipe (
            .clk   (clk),
            .rst_n (rst_n),
            .sel_i (sel0[b]),
            .rd_i  (rd0[b]),
            .sel_o (sel_q[b]),
            .rd_o  (rd_q[b])
        );
    end

    // Response mux: route each bank's last stage to its owner; writes ack with zero data.
    always_comb begin
        resp_valid_o = '0;
        resp_rd_o    = '0;
        rdata_o      = '0;
        for (int p = 0; p < MUX_IN; p++) begin
            for (int b = 0; b < MUX_OUT; b++) begin
                if (sel_q[b][p]) begin
                    resp_valid_o[p] = 1'b1;
                    if (rd_q[b]) begin
                        resp_rd_o[p]              = 1'b1;
                        rdata_o[p*DATA_W +: DATA_W] = rdata_i[b*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Counter next state: clear wins, otherwise count stalls until all ones.
    always_comb begin
        cnt_d = cnt_q;
        for (int p = 0; p < MUX_IN; p++) begin
            if (clr_cnt_i) begin
                cnt_d[p] = '0;
            end else if (stall[p] && (cnt_q[p] != {CNT_W{1'b1}})) begin
                cnt_d[p] = cnt_q[p] + CNT_W'(1);
            end
        end
    end

    // Conflict counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;

`ifndef SYNTHESIS
    for (genvar b = 0; b < MUX_OUT; b++) begin : g_chk_bank
        a_peid_onehot : assert property (@(posedge clk) disable iff (!rst_n)
            $onehot0(peID_i[b*MUX_IN +: MUX_IN]));
    end

    for (genvar p = 0; p < MUX_IN; p++) begin : g_chk_pe
        logic [MUX_OUT-1:0] col;
        // Gather this PE's bit from every bank's last stage.
        always_comb begin
            col = '0;
            for (int b = 0; b < MUX_OUT; b++) begin
                col[b] = sel_q[b][p];
            end
        end
        a_one_bank_per_pe : assert property (@(posedge clk) disable iff (!rst_n)
            $onehot0(col));
    end
`endif

endmodule

// File: tb/tb_crossbar_out_resp.sv
module tb_crossbar_out_resp;

    typedef struct packed {
        int             due;
        logic [3:0]     v;
        logic [3:0]     rd;
        logic [3:0][1:0] bank;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   rden, wren;
    logic [15:0]  peid;
    logic [127:0] rdata;
    logic         clr;

    logic [3:0]   gnt_a  [3];
    logic [3:0]   v_a    [3];
    logic [3:0]   rd_a   [3];
    logic [127:0] rdo_a  [3];
    logic [63:0]  cnt_a  [2];
    logic [31:0]  cnt_s;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    int   lat [3]  = '{1, 2, 1};
    exp_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u_l1: latency 1, u_l2: latency 2, u_s: latency 1 with narrow counters for saturation
    crossbar_out_resp #(.MUX_IN(4), .MUX_OUT(4), .RD_LATENCY(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst_n(rst_n), .rden_i(rden), .wren_i(wren), .peID_i(peid),
        .rdata_i(rdata), .clr_cnt_i(clr), .gnt_o(gnt_a[0]), .resp_valid_o(v_a[0]),
        .resp_rd_o(rd_a[0]), .rdata_o(rdo_a[0]), .conflict_cnt_o(cnt_a[0]));

    crossbar_out_resp #(.MUX_IN(4), .MUX_OUT(4), .RD_LATENCY(2), .CNT_W(16)) u_l2 (
        .clk(clk), .rst_n(rst_n), .rden_i(rden), .wren_i(wren), .peID_i(peid),
        .rdata_i(rdata), .clr_cnt_i(clr), .gnt_o(gnt_a[1]), .resp_valid_o(v_a[1]),
        .resp_rd_o(rd_a[1]), .rdata_o(rdo_a[1]), .conflict_cnt_o(cnt_a[1]));

    crossbar_out_resp #(.MUX_IN(4), .MUX_OUT(4), .RD_LATENCY(1), .CNT_W(8)) u_s (
        .clk(clk), .rst_n(rst_n), .rden_i(rden), .wren_i(wren), .peID_i(peid),
        .rdata_i(rdata), .clr_cnt_i(clr), .gnt_o(gnt_a[2]), .resp_valid_o(v_a[2]),
        .resp_rd_o(rd_a[2]), .rdata_o(rdo_a[2]), .conflict_cnt_o(cnt_s));

    // Scoreboard monitor: pop the entry due this cycle (or expect silence) and compare.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                exp_t         e;
                logic [3:0]   ev, er;
                logic [127:0] ed;
                bit           have;
                ev = '0; er = '0; ed = '0; have = 1'b0;
                if (d == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
                if (d == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
                if (d == 2 && q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); have = 1'b1; end
                if (have) begin
                    ev = e.v;
                    er = e.rd;
                    for (int p = 0; p < 4; p++)
                        if (e.rd[p]) ed[p*32 +: 32] = rdata[int'(e.bank[p])*32 +: 32];
                end
                checks++;
                if (v_a[d] !== ev || rd_a[d] !== er || rdo_a[d] !== ed) begin
                    failures++;
                    $display("FAIL resp dut%0d cyc=%0d valid=%b exp=%b rd=%b exp=%b data=%h exp=%h",
                             d, cyc, v_a[d], ev, rd_a[d], er, rdo_a[d], ed);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic flush();
        q0.delete(); q1.delete(); q2.delete();
    endtask

    // Drive one cycle of inputs and push the responses they should produce.
    task automatic step(input logic [3:0] r, input logic [3:0] w, input logic [15:0] pid,
                        input logic [127:0] dat, input logic c);
        exp_t e;
        @(negedge clk);
        rden = r; wren = w; peid = pid; rdata = dat; clr = c;
        e = '0;
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 4; b++)
                if (pid[b*4 + p]) begin
                    e.v[p]    = 1'b1;
                    e.rd[p]   = r[p] & ~w[p];
                    e.bank[p] = 2'(b);
                end
        if (e.v != 4'b0 && rst_n) begin
            e.due = cyc + lat[0]; q0.push_back(e);
            e.due = cyc + lat[1]; q1.push_back(e);
            e.due = cyc + lat[2]; q2.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; rden = '0; wren = '0; clr = 1'b0; rdata = '0; peid = 16'h0040;
        flush();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (gnt_a[d] !== 4'b0100) begin failures++; $display("FAIL reset_gnt dut%0d got=%b exp=0100", d, gnt_a[d]); end
            checks++;
            if (v_a[d] !== 4'b0 || rd_a[d] !== 4'b0 || rdo_a[d] !== 128'b0) begin
                failures++; $display("FAIL reset_resp dut%0d valid=%b rd=%b data=%h exp zero", d, v_a[d], rd_a[d], rdo_a[d]);
            end
        end
        checks++;
        if (cnt_a[0] !== 64'b0 || cnt_a[1] !== 64'b0 || cnt_s !== 32'b0) begin
            failures++; $display("FAIL reset_cnt got=%h %h %h exp zero", cnt_a[0], cnt_a[1], cnt_s);
        end
        @(negedge clk);
        peid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_single_read();
        logic [127:0] dat;
        dat = {32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333};
        step(4'b0001, 4'b0000, 16'h0100, dat, 1'b0);
        checks++;
        if (gnt_a[0] !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt_a[0]); end
        step(4'b0000, 4'b0000, 16'h0000, dat, 1'b0);
        checks++;
        if (v_a[0] !== 4'b0001 || rd_a[0] !== 4'b0001 || rdo_a[0] !== {96'b0, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL single_resp valid=%b rd=%b data=%h exp 0001 0001 deadbeef", v_a[0], rd_a[0], rdo_a[0]);
        end
        step(4'b0000, 4'b0000, 16'h0000, dat, 1'b0);
    endtask

    task automatic test_conflict();
        logic [127:0] dat;
        dat = {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
        step(4'b0000, 4'b0000, 16'h0000, dat, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b1010, 4'b0000, 16'h0002, dat, 1'b0);
            checks++;
            if (gnt_a[0] !== 4'b0010) begin failures++; $display("FAIL conflict_gnt i=%0d got=%b exp=0010", i, gnt_a[0]); end
        end
        step(4'b0000, 4'b0000, 16'h0000, dat, 1'b0);
        checks++;
        if (cnt_a[0][63:48] !== 16'd3 || cnt_a[1][63:48] !== 16'd3 || cnt_s[31:24] !== 8'd3) begin
            failures++; $display("FAIL conflict_cnt_pe3 got=%0d %0d %0d exp=3", cnt_a[0][63:48], cnt_a[1][63:48], cnt_s[31:24]);
        end
        checks++;
        if (cnt_a[0][47:0] !== 48'd0) begin failures++; $display("FAIL conflict_cnt_others got=%h exp=0", cnt_a[0][47:0]); end
        step(4'b0000, 4'b0000, 16'h0000, dat, 1'b0);
    endtask

    task automatic test_parallel();
        logic [127:0] dat;
        dat = {32'hC3C3_0003, 32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
        step(4'b0101, 4'b1010, 16'h8421, dat, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, dat, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, dat, 1'b0);
        checks++;
        if (v_a[1] !== 4'b1111 || rd_a[1] !== 4'b0101 ||
            rdo_a[1] !== {32'h0, 32'hC2C2_0002, 32'h0, 32'hC0C0_0000}) begin
            failures++; $display("FAIL parallel_l2 valid=%b rd=%b data=%h", v_a[1], rd_a[1], rdo_a[1]);
        end
    endtask

    task automatic test_rw_same_pe();
        logic [127:0] dat;
        dat = {32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
        step(4'b0100, 4'b0100, 16'h0040, dat, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, dat, 1'b0);
        checks++;
        if (v_a[0][2] !== 1'b1 || rd_a[0][2] !== 1'b0 || rdo_a[0][95:64] !== 32'h0) begin
            failures++; $display("FAIL rw_same_pe valid=%b rd=%b data=%h exp v=1 rd=0 data=0", v_a[0][2], rd_a[0][2], rdo_a[0][95:64]);
        end
        step(4'b0000, 4'b0000, 16'h0000, dat, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] dat;
        logic [15:0]  pid;
        logic [3:0]   used, r, w;
        for (int i = 0; i < 5; i++) begin
            dat = '0;
            dat[127:96] = 32'hB000_0000 + 32'(i);
            step(i < 4 ? 4'b0001 : 4'b0000, 4'b0000, i < 4 ? 16'h1000 : 16'h0000, dat, 1'b0);
            if (i > 0) begin
                checks++;
                if (v_a[0][0] !== 1'b1 || rdo_a[0][31:0] !== 32'hB000_0000 + 32'(i)) begin
                    failures++; $display("FAIL b2b i=%0d valid=%b data=%h exp 1 %h", i, v_a[0][0], rdo_a[0][31:0], 32'hB000_0000 + 32'(i));
                end
            end
        end
        for (int i = 0; i < 200; i++) begin
            pid = '0; used = '0;
            for (int b = 0; b < 4; b++) begin
                int p;
                p = int'($urandom_range(0, 4));
                if (p < 4 && !used[p]) begin used[p] = 1'b1; pid[b*4 + p] = 1'b1; end
            end
            r = 4'($urandom); w = 4'($urandom);
            dat = {$urandom, $urandom, $urandom, $urandom};
            step(r, w, pid, dat, 1'b0);
        end
        step(4'b0000, 4'b0000, 16'h0000, '0, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, '0, 1'b0);
    endtask

    task automatic test_saturation();
        step(4'b0000, 4'b0000, 16'h0000, '0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(4'b0001, 4'b0000, 16'h0000, '0, 1'b0);
            if (i == 100) begin
                checks++;
                if (cnt_s[7:0] !== 8'd100) begin failures++; $display("FAIL sat_mid got=%0d exp=100", cnt_s[7:0]); end
            end
        end
        step(4'b0000, 4'b0000, 16'h0000, '0, 1'b0);
        checks++;
        if (cnt_s[7:0] !== 8'hFF) begin failures++; $display("FAIL sat_narrow got=%h exp=ff", cnt_s[7:0]); end
        checks++;
        if (cnt_a[0][15:0] !== 16'd300) begin failures++; $display("FAIL sat_wide got=%0d exp=300", cnt_a[0][15:0]); end
        step(4'b0001, 4'b0000, 16'h0000, '0, 1'b1);
        step(4'b0000, 4'b0000, 16'h0000, '0, 1'b0);
        checks++;
        if (cnt_s !== 32'h0 || cnt_a[0] !== 64'h0) begin
            failures++; $display("FAIL clr_priority got=%h %h exp=0", cnt_s, cnt_a[0]);
        end
    endtask

    task automatic test_reset_midflight();
        logic [127:0] dat;
        dat = {32'h0, 32'h9999_9999, 32'h0, 32'h0};
        step(4'b0001, 4'b0000, 16'h0100, dat, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; rden = '0; wren = '0; peid = '0; clr = 1'b0;
        flush();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (v_a[d] !== 4'b0 || rd_a[d] !== 4'b0 || rdo_a[d] !== 128'b0) begin
                failures++; $display("FAIL midrst_during dut%0d valid=%b rd=%b data=%h exp zero", d, v_a[d], rd_a[d], rdo_a[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (v_a[1] !== 4'b0 || rd_a[1] !== 4'b0 || rdo_a[1] !== 128'b0 || cnt_a[1] !== 64'b0) begin
            failures++; $display("FAIL midrst_after valid=%b rd=%b data=%h cnt=%h exp zero", v_a[1], rd_a[1], rdo_a[1], cnt_a[1]);
        end
        step(4'b0010, 4'b0000, 16'h0020, dat, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, dat, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, dat, 1'b0);
        step(4'b0000, 4'b0000, 16'h0000, dat, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1; rden = '0; wren = '0; peid = '0; rdata = '0; clr = 1'b0;
        test_reset();
        test_single_read();
        test_conflict();
        test_parallel();
        test_rw_same_pe();
        test_back_to_back();
        test_saturation();
        test_reset_midflight();
        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crossbar_out_resp.md
# crossbar_out_resp

Response-side crossbar for the shared instruction/data SRAM banks. It sits between the four SRAM banks and the PEs, and closes each request that the request crossbar has granted:

- Each cycle it captures the per-bank PE selection and delays it by the SRAM read latency.
- It steers each bank's read data back to the owning PE with a response-valid strobe.
- It drives the same-cycle grant to the PEs.
- It counts per-PE conflict stalls for performance monitoring.

## Interface
Parameters:
- MUX_IN, 4, number of PEs (requesters).
- MUX_OUT, 4, number of SRAM banks.
- RD_LATENCY, 1, SRAM read latency in cycles; legal values 1 or 2.
- CNT_W, 16, width of each conflict counter.

Ports:
- clk  input  1  clock. Single clock domain.
- rst_n  input  1  reset. Asynchronous assertion, active-low.
- rden_i  input  MUX_IN  per-PE read request. Same vector the request crossbar receives.
- wren_i  input  MUX_IN  per-PE write request.
- peID_i  input  MUX_OUT*MUX_IN  per-bank one-hot PE selection from the request crossbar; bank b occupies bits [b*MUX_IN +: MUX_IN].
- rdata_i  input  MUX_OUT*32  per-bank SRAM read data, valid RD_LATENCY cycles after the access.
- clr_cnt_i  input  1  synchronous clear of all conflict counters.
- gnt_o  output  MUX_IN  per-PE grant for the current cycle (combinational).
- resp_valid_o  output  MUX_IN  per-PE response strobe, one cycle per granted access.
- resp_rd_o  output  MUX_IN  response is a read completion (valid only with resp_valid_o).
- rdata_o  output  MUX_IN*32  per-PE read data.
- conflict_cnt_o  output  MUX_IN*CNT_W  per-PE saturating count of stalled request cycles.

## Operation
**Grant and conflicts**
- req[p] = rden_i[p] | wren_i[p].
- gnt_o[p] = OR over banks b of peID_i[b][p].
- stall[p] = req[p] & ~gnt_o[p]. A stalled PE must hold its request; this block issues no response for it.

**Per-bank capture**
- sel0[b] = peID_i[b].
- rd0[b] = |(peID_i[b] & rden_i & ~wren_i). If a PE asserts both rden and wren, the access is a write.

**Delay line**
- Per bank: RD_LATENCY stages of {sel, rd}, registered every cycle with no enable.
- The last stage is {sel_q[b], rd_q[b]}.

**Response mux** (combinational from the last stage)
- resp_valid_o[p] = OR over b of sel_q[b][p].
- resp_rd_o[p] = OR over b of (sel_q[b][p] & rd_q[b]).
- rdata_o[p] = rdata_i of the bank b with sel_q[b][p] = 1, when that bank's rd_q[b] = 1; otherwise 32'h0.
- A PE targets at most one bank per cycle, so at most one sel_q[b][p] is set per p. Two set bits is illegal and flagged by an assertion.

**Conflict counters**
- Per PE: clr_cnt_i → 0.
- Else if stall[p] and the counter is below its maximum → +1.
- Else hold at the saturation value {CNT_W{1}}.
- Clear has priority over increment in the same cycle.

**Illegal input:** more than one bit set in peID_i[b]. Covered by an assertion; behaviour in RTL is undefined.

## Timing
- Reset values: all delay stages 0 and all counters 0. Hence resp_valid_o = 0, resp_rd_o = 0, rdata_o = 0, conflict_cnt_o = 0.
- gnt_o depends only on peID_i and is not reset-gated.
- Latency: an access granted at cycle T gives resp_valid_o at T+RD_LATENCY, for exactly one cycle.
- Throughput: one response per PE per cycle. Back-to-back granted accesses give back-to-back strobes.
- Writes also produce resp_valid_o, with resp_rd_o = 0 and rdata_o = 0. This is the write acknowledge.
- Reset mid-operation: in-flight entries are dropped, and no response is emitted for accesses granted before or during reset.
- Counters update at the clock edge following a stalled cycle. conflict_cnt_o is the registered value.
- No back-pressure from the PEs: a PE must accept resp_valid_o in the cycle it is asserted.

## Structure
- Shared package crossbar_pkg:
  - MUX_IN and MUX_OUT defaults, BIT_CONF (the bank-select bit position), and the bank-count constant.
  - Reused by the request crossbar, this block and the SRAM wrapper.
- One sub-module, crossbar_resp_pipe:
  - A parameterised {sel, rd} delay line of depth RD_LATENCY.
  - Instantiated MUX_OUT times.
- The response mux, grant logic and counters live in the top module.

## Test plan
- **Single read.** Reset, then PE0 reads bank 2 with RD_LATENCY=1; peID_i bank2 = 4'b0001, and rdata_i bank2 = 32'hDEADBEEF at T+1. Expect gnt_o = 4'b0001 at T, then at T+1 resp_valid_o[0] = 1, resp_rd_o[0] = 1, rdata_o[0] = 32'hDEADBEEF, and no other PE valid.
- **Conflict.** PE1 and PE3 both read bank 0 for 3 cycles, with peID_i bank0 = 4'b0010. Expect gnt_o[3] = 0 and conflict_cnt_o[3] = 3 afterwards. PE1 gets 3 responses; PE3 gets none.
- **Parallel banks.** All four PEs hit distinct banks with mixed read/write, RD_LATENCY=2. Expect all four resp_valid_o at T+2. Write PEs see resp_rd_o = 0 and rdata_o = 0; read PEs get their own bank's data.
- **Saturation and clear.** Force a PE stall for 70000 cycles with CNT_W=16. Expect conflict_cnt_o = 16'hFFFF. Then assert clr_cnt_i together with a stall in the same cycle; expect 0 next cycle.
- **Reset mid-flight.** Grant a read at T with RD_LATENCY=2 and pulse rst_n low at T+1. Expect no resp_valid_o at T+2 and all outputs 0.
- **Read and write from the same PE.** PE2 asserts both rden_i and wren_i. Expect resp_valid_o[2] = 1 with resp_rd_o[2] = 0 and rdata_o[2] = 0.
